// File: rtl/ram_fifo_ctrl.sv
// rtl/ram_fifo_ctrl.sv - FIFO controller driving an external two-port RAM
// with read prefetch into a 2-entry skid buffer for full-rate output.
module ram_fifo_ctrl #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 4096
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH)-1:0]   ram_waddr,
  output logic                       ram_we,
  output logic [WIDTH-1:0]           ram_wdata,
  output logic [$clog2(DEPTH)-1:0]   ram_raddr,
  output logic                       ram_re,
  input  logic [WIDTH-1:0]           ram_rdata,
  output logic [$clog2(DEPTH)+1:0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      mem_cnt;
  logic             inflight;
  logic [1:0]       buf_cnt;
  logic [WIDTH-1:0] buf0;
  logic [WIDTH-1:0] buf1;

  logic             push;
  logic             pop;
  logic [2:0]       pend;

  // Full is judged on RAM residency only; prefetched words have left the RAM.
  assign in_ready  = (mem_cnt < DEPTH_C);
  assign push      = in_valid & in_ready & rst_n;
  assign ram_we    = push;
  assign ram_waddr = wptr;
  assign ram_wdata = in_data;

  assign out_valid = rst_n & (buf_cnt != 2'd0);
  assign out_data  = buf0;
  assign pop       = out_valid & out_ready;

  // Issue a read only if the word is guaranteed a skid slot when it returns.
  assign pend      = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign ram_re    = rst_n & (mem_cnt != '0) & (pend < 3'd2);
  assign ram_raddr = rptr;

  assign level = (AW+2)'(mem_cnt) + (AW+2)'(inflight) + (AW+2)'(buf_cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (ram_re)
        rptr <= rptr + AW'(1);
      mem_cnt  <= mem_cnt + (AW+1)'(push) - (AW+1)'(ram_re);
      inflight <= ram_re;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_cnt <= 2'd0;
    end else begin
      case ({inflight, pop})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Skid payload is unreset; buf0 is always the head entry.
  always_ff @(posedge clk) begin
    if (inflight && pop) begin
      if (buf_cnt == 2'd2) begin
        buf0 <= buf1;
        buf1 <= ram_rdata;
      end else begin
        buf0 <= ram_rdata;
      end
    end else if (inflight) begin
      if (buf_cnt == 2'd0)
        buf0 <= ram_rdata;
      else
        buf1 <= ram_rdata;
    end else if (pop) begin
      buf0 <= buf1;
    end
  end

  skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight && !pop && buf_cnt == 2'd2));

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb/tb_ram_fifo_ctrl.sv - scoreboard bench for ram_fifo_ctrl with a
// behavioural two-port RAM (DEPTH=8, WIDTH=16).
module tb_ram_fifo_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    ram_waddr;
  logic             ram_we;
  logic [WIDTH-1:0] ram_wdata;
  logic [AW-1:0]    ram_raddr;
  logic             ram_re;
  logic [WIDTH-1:0] ram_rdata = '0;
  logic [AW+1:0]    level;

  ram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_waddr(ram_waddr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_rdata(ram_rdata),
    .level(level)
  );

  always #5 clk = ~clk;

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_raddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  logic [WIDTH-1:0] exp_q[$];
  int cyc = 0;
  int tb_mem, tb_infl, tb_buf, pops, first_pop, last_pop, max_level, wwraps, rwraps;
  int exp_wa, exp_ra;
  bit p;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: tracks occupancy from observed port events and scores output.
  always @(negedge clk) begin
    if (!rst_n) begin
      tb_mem = 0; tb_infl = 0; tb_buf = 0; pops = 0; first_pop = 0; last_pop = 0;
      max_level = 0; wwraps = 0; rwraps = 0; exp_wa = 0; exp_ra = 0;
      exp_q.delete();
    end else begin
      p = out_valid && out_ready;
      check("level", level, tb_mem + tb_infl + tb_buf);
      if (int'(level) > max_level) max_level = int'(level);
      if (ram_re) check("re_nonempty", tb_mem > 0, 1);
      if (tb_buf == 2 && !p) check("re_skid_full", ram_re, 0);
      if (in_valid && in_ready) begin
        check("we", ram_we, 1);
        check("wdata", ram_wdata, in_data);
        check("waddr", ram_waddr, exp_wa);
        exp_q.push_back(in_data);
        if (exp_wa == DEPTH-1) wwraps++;
        exp_wa = (exp_wa + 1) % DEPTH;
      end
      if (ram_re) begin
        check("raddr", ram_raddr, exp_ra);
        if (exp_ra == DEPTH-1) rwraps++;
        exp_ra = (exp_ra + 1) % DEPTH;
      end
      if (p) begin
        if (exp_q.size() == 0) check("unexpected_out", 1, 0);
        else check("out_data", out_data, exp_q.pop_front());
        pops++;
        if (pops == 1) first_pop = cyc;
        last_pop = cyc;
      end
      tb_mem  = tb_mem + int'(ram_we) - int'(ram_re);
      tb_buf  = tb_buf + tb_infl - int'(p);
      tb_infl = int'(ram_re);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // mode: 0 hold out_ready, 1 random, 2 toggle each cycle
  task automatic wait_drain(input int budget, input string name, input int mode);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) out_ready = ~out_ready;
      @(posedge clk); #1;
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic push_n(input int count, input int base, input int mode);
    int n = 0;
    int guard = 0;
    bit acc;
    while (n < count && guard < 500) begin
      in_valid = 1'b1;
      in_data  = WIDTH'(base + n);
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      else if (mode == 2) out_ready = ~out_ready;
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) n++;
      guard++;
    end
    in_valid = 1'b0;
    check("push_budget", n, count);
  endtask

  initial begin
    // Reset state, with in_valid high to show ram_we is forced low
    rst_n = 1'b0; in_valid = 1'b1;
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_level", level, 0);
    check("rst_we", ram_we, 0);
    check("rst_re", ram_re, 0);

    // Single word 0xA5
    do_reset();
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h00A5; out_ready = 1'b1;
    #1;
    check("t1_we", ram_we, 1);
    check("t1_waddr", ram_waddr, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("t1_re", ram_re, 1);
    check("t1_raddr", ram_raddr, 0);
    wait_drain(20, "t1_drain", 0);
    check("t1_pops", pops, 1);
    check("t1_level", level, 0);

    // Continuous stream of 100 words
    do_reset();
    out_ready = 1'b1;
    push_n(100, 0, 0);
    wait_drain(30, "t2_drain", 0);
    check("t2_pops", pops, 100);
    check("t2_no_bubble", last_pop - first_pop, 99);
    check("t2_max_level_le3", max_level <= 3, 1);

    // Fill with out_ready low: 8 in RAM + 2 prefetched
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1; in_data = WIDTH'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("t3_accepted", exp_q.size(), 10);
    check("t3_level", level, 10);
    check("t3_in_ready_low", in_ready, 0);
    check("t3_out_valid", out_valid, 1);
    check("t3_head", out_data, 0);
    out_ready = 1'b1;
    wait_drain(30, "t3_drain", 0);
    check("t3_pops", pops, 10);
    check("t3_in_ready_back", in_ready, 1);

    // Wrap-around with random backpressure
    do_reset();
    push_n(20, 16'h100, 1);
    wait_drain(200, "t4_drain", 1);
    check("t4_pops", pops, 20);
    check("t4_wwraps", wwraps, 2);
    check("t4_rwraps", rwraps, 2);

    // Alternating backpressure burst
    do_reset();
    out_ready = 1'b0;
    push_n(16, 16'h200, 2);
    wait_drain(100, "t5_drain", 2);
    check("t5_pops", pops, 16);

    // Asynchronous reset mid-burst
    do_reset();
    out_ready = 1'b0;
    push_n(5, 16'h300, 0);
    check("t6_pre_valid", out_valid, 1);
    check("t6_pre_level", level, 5);
    in_valid = 1'b1; in_data = 16'h0077;
    #2 rst_n = 1'b0;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_re", ram_re, 0);
    check("t6_we", ram_we, 0);
    check("t6_level_rst", level, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("t6_level", level, 0);
    check("t6_valid_after", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 16'h003C; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain(20, "t6_drain", 0);
    check("t6_pops", pops, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
